circ_vec_mtx_mul_seq: RTL

CIRC_VEC_MTX_MUL_SEQ -- requirements
Module: circ_vec_mtx_mul_seq

---
 rtl/mat_pkg.sv | 21 ++
 rtl/mod_dot_row.sv | 41 ++++
 rtl/circ_vec_mtx_mul_seq.sv | 86 ++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the modular matrix blocks: Mersenne modulus,
// FSM encoding, and the fold-based reduction used after wide accumulation.
package mat_pkg;
  localparam int unsigned DEF_WORD_WIDTH = 31;
  localparam logic [63:0] MODULUS        = (64'd1 << DEF_WORD_WIDTH) - 64'd1;
  localparam int unsigned MAX_WORD_WIDTH = 63;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  // Reduce x mod 2^w-1. Four folds bring a (2w+log2N)-bit sum down to at
  // most 2^w-1 (== P), which is then mapped to its canonical value 0.
  function automatic logic [63:0] mod_fold(input logic [127:0] x, input int unsigned w);
    logic [127:0] acc;
    logic [127:0] mask;
    mask = (128'd1 << w) - 128'd1;
    acc  = x;
    for (int it = 0; it < 4; it++) acc = (acc & mask) + (acc >> w);
    if (acc == mask) acc = '0;
    return acc[63:0];
  endfunction
endpackage

// File: rtl/mod_dot_row.sv
// Combinational N-element dot product mod 2^WORD_WIDTH-1: full-width
// products, balanced adder tree, single Mersenne fold at the root.
module mod_dot_row
  import mat_pkg::*;
#(
  parameter int WORD_WIDTH = 31,
  parameter int MTX_SIZE   = 16
) (
  input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] a,
  input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] b,
  output logic [WORD_WIDTH-1:0]               y
);
  localparam int LOG_N = $clog2(MTX_SIZE);
  localparam int ACC_W = 2*WORD_WIDTH + LOG_N;

  logic [MTX_SIZE-1:0][2*WORD_WIDTH-1:0] prod;

  for (genvar i = 0; i < MTX_SIZE; i++) begin : g_mul
    assign prod[i] = {{WORD_WIDTH{1'b0}}, a[i]} * {{WORD_WIDTH{1'b0}}, b[i]};
  end

  for (genvar l = 0; l <= LOG_N; l++) begin : lvl
    logic [(MTX_SIZE>>l)-1:0][ACC_W-1:0] s;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < MTX_SIZE; i++) begin : g_l
        assign s[i] = {{LOG_N{1'b0}}, prod[i]};
      end
    end else begin : g_sum
      for (genvar j = 0; j < (MTX_SIZE>>l); j++) begin : g_s
        assign s[j] = lvl[l-1].s[2*j] + lvl[l-1].s[2*j+1];
      end
    end
  end

  logic [63:0]             red;
  logic [63-WORD_WIDTH:0]  red_unused;

  assign red        = mod_fold({{(128-ACC_W){1'b0}}, lvl[LOG_N].s[0]}, WORD_WIDTH);
  assign red_unused = red[63:WORD_WIDTH];
  assign y          = red[WORD_WIDTH-1:0];
endmodule

// File: rtl/circ_vec_mtx_mul_seq.sv
// Sequential r = v * C for a circulant C given by its first row; one result
// column per cycle through a shared modular dot-product row.
module circ_vec_mtx_mul_seq
  import mat_pkg::*;
#(
  parameter int WORD_WIDTH = 31,
  parameter int MTX_SIZE   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] mtx_row,
  input  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] vec,
  output logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] result,
  output logic                                out_valid,
  input  logic                                out_ready
);
  localparam int                    LOG_N = $clog2(MTX_SIZE);
  localparam logic [LOG_N-1:0]      LAST  = LOG_N'(MTX_SIZE-1);
  localparam logic [WORD_WIDTH-1:0] P     = '1;

  state_t                              state, state_nxt;
  logic [LOG_N-1:0]                    k;
  logic [MTX_SIZE-1:0][WORD_WIDTH-1:0] c_reg, v_reg, col, res;
  logic [WORD_WIDTH-1:0]               dot;

  // Column k of C is c[(k-i) mod N]; N is a power of two so the
  // subtraction simply wraps in LOG_N bits.
  for (genvar i = 0; i < MTX_SIZE; i++) begin : g_col
    localparam logic [LOG_N-1:0] OFF = LOG_N'(i);
    assign col[i] = c_reg[k - OFF];
  end

  mod_dot_row #(
    .WORD_WIDTH(WORD_WIDTH),
    .MTX_SIZE  (MTX_SIZE)
  ) u_dot (
    .a(v_reg),
    .b(col),
    .y(dot)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = COMPUTE;
      end
      COMPUTE: if (k == LAST) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      k     <= '0;
      c_reg <= '0;
      v_reg <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        k <= '0;
        // The alias P of zero is canonicalised once at capture.
        for (int i = 0; i < MTX_SIZE; i++) begin
          c_reg[i] <= (mtx_row[i] == P) ? '0 : mtx_row[i];
          v_reg[i] <= (vec[i] == P) ? '0 : vec[i];
        end
      end else if (state == COMPUTE) begin
        res[k] <= dot;
        k      <= k + LOG_N'(1);
      end
    end
  end

  assign result = res;
endmodule
